// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller for the iterative M-extension divider.
//   Accepts DIV/DIVU/REM/REMU requests. Divide-by-zero, signed overflow and
//   result-cache hits are answered without running the divider. All other
//   requests are issued to the divider. Responses return the selected word
//   with the request's destination tag. A flush kills the in-flight request.
//
// Ports:
//   clock, nreset                      clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o            request handshake
//   req_op_i                           00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_a_i, req_b_i, req_tag_i        dividend, divisor, destination tag
//   flush_i                            kill the in-flight request
//   resp_valid_o/resp_ready_i          response handshake
//   resp_data_o, resp_tag_o            selected quotient/remainder and its tag
//   div_a_o, div_b_o, div_signed_o     divider operands and signedness
//   div_in_valid_o/div_in_ready_i      divider start handshake
//   div_q_i, div_r_i                   divider quotient and remainder
//   div_out_valid_i/div_out_ready_o    divider result handshake
module div_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned TAG_W    = 5,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [XLEN-1:0]  req_a_i,
  input  logic [XLEN-1:0]  req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic [XLEN-1:0]  div_a_o,
  output logic [XLEN-1:0]  div_b_o,
  output logic             div_signed_o,
  output logic             div_in_valid_o,
  input  logic             div_in_ready_i,
  input  logic [XLEN-1:0]  div_q_i,
  input  logic [XLEN-1:0]  div_r_i,
  input  logic             div_out_valid_i,
  output logic             div_out_ready_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_next;

  // latched request
  logic             rem_q;
  logic             sgn_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  data_q;

  // one-entry result cache
  logic             cache_vld;
  logic             cache_sgn;
  logic [XLEN-1:0]  cache_a;
  logic [XLEN-1:0]  cache_b;
  logic [XLEN-1:0]  cache_q;
  logic [XLEN-1:0]  cache_r;

  // request decode
  logic             req_sgn;
  logic             req_rem;
  logic             accept;
  logic             div_zero;
  logic             ovf;
  logic             hit;
  logic             fast;
  logic [XLEN-1:0]  fast_data;
  logic             capture;

  // accept is derived from state directly rather than from req_ready_o so
  // that the ready output and the next-state logic stay free of a loop.
  always_comb begin
    req_sgn   = ~req_op_i[0];
    req_rem   = req_op_i[1];
    accept    = (state == S_IDLE) & req_valid_i & ~flush_i;
    div_zero  = (req_b_i == '0);
    ovf       = req_sgn & (req_a_i == MIN_NEG) & (req_b_i == '1);
    hit       = CACHE_EN & cache_vld & (cache_a == req_a_i) &
                (cache_b == req_b_i) & (cache_sgn == req_sgn);
    fast      = div_zero | ovf | hit;
    fast_data = '0;
    if (div_zero) begin
      fast_data = req_rem ? req_a_i : '1;
    end else if (ovf) begin
      fast_data = req_rem ? '0 : MIN_NEG;
    end else if (hit) begin
      fast_data = req_rem ? cache_r : cache_q;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    capture         = 1'b0;
    // gated by nreset so every output reads 0 while reset is held
    req_ready_o     = nreset & (state == S_IDLE) & ~flush_i;
    div_in_valid_o  = 1'b0;
    div_out_ready_o = 1'b0;
    resp_valid_o    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid_i & ~flush_i) begin
          state_next = fast ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_in_valid_o = 1'b1;
        if (div_in_ready_i) begin
          // the divider has started; a flush now must still absorb its result
          state_next = flush_i ? S_DRAIN : S_WAIT;
        end else if (flush_i) begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        div_out_ready_o = 1'b1;
        if (div_out_valid_i) begin
          if (flush_i) begin
            state_next = S_IDLE;
          end else begin
            capture    = 1'b1;
            state_next = S_RESP;
          end
        end else if (flush_i) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        div_out_ready_o = 1'b1;
        if (div_out_valid_i) begin
          state_next = S_IDLE;
        end
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i | flush_i) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rem_q     <= 1'b0;
      sgn_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      data_q    <= '0;
      cache_vld <= 1'b0;
      cache_sgn <= 1'b0;
      cache_a   <= '0;
      cache_b   <= '0;
      cache_q   <= '0;
      cache_r   <= '0;
    end else begin
      if (accept) begin
        rem_q <= req_rem;
        sgn_q <= req_sgn;
        a_q   <= req_a_i;
        b_q   <= req_b_i;
        tag_q <= req_tag_i;
        if (fast) begin
          data_q <= fast_data;
        end
      end
      if (capture) begin
        data_q <= rem_q ? div_r_i : div_q_i;
        if (CACHE_EN) begin
          cache_vld <= 1'b1;
          cache_sgn <= sgn_q;
          cache_a   <= a_q;
          cache_b   <= b_q;
          cache_q   <= div_q_i;
          cache_r   <= div_r_i;
        end
      end
    end
  end

  assign div_a_o      = a_q;
  assign div_b_o      = b_q;
  assign div_signed_o = sgn_q;
  assign resp_data_o  = data_q;
  assign resp_tag_o   = tag_q;

endmodule
